instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/HALT sequencer owning the PC and the
// held instruction word presented to the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        pc_enable,
    input  logic        stall,
    input  logic        branch_cond,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        pc_load;
    logic        instr_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs are masked by rst so nothing is requested or
    // reported while reset is held, regardless of the registered state.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        pc_load     = 1'b0;
        instr_load  = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req   = !rst;
                instr_load = imem_ack;
                if (imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = !rst;
                if (!stall) begin
                    if (pc_enable) begin
                        pc_load    = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                halted = !rst;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        unique case (pc_src)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = branch_cond ? branch_target : pc_plus4;
            2'b10: next_pc = jump_target;
            2'b11: next_pc = reg_target;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC & ~32'd3;
            instr <= 32'd0;
        end else begin
            if (instr_load) begin
                instr <= imem_rdata;
            end
            if (pc_load) begin
                pc <= next_pc & ~32'd3;
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:26];

endmodule
